// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the iterative restoring divider.
// Optional divide-by-zero early exit is controlled by SEQ_DIVIDER_DIVZERO_EN in seq_divider.sv.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W_DEFAULT = 4;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, conditionally subtract.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic [W:0]   rem_in,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W:0] trial;
    logic [W:0] divisor_ext;

    always_comb begin
        trial       = {rem_in[W-1:0], dividend_bit};
        divisor_ext = {1'b0, divisor};
        // A set top bit would already exceed any W-bit divisor; it stays clear in normal operation.
        q_bit       = rem_in[W] | (trial >= divisor_ext);
        rem_out     = q_bit ? (trial - divisor_ext) : trial;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider: one quotient bit per clock, one-cycle done strobe.
// Define SEQ_DIVIDER_DIVZERO_EN to add the div_by_zero flag and a one-cycle exit for B==0.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output div_state_t   fsm_state
`ifdef SEQ_DIVIDER_DIVZERO_EN
    ,
    output logic         div_by_zero
`endif
);

    // Handshake: start is accepted at a rising edge when the FSM is IDLE or DONE
    // (busy=0); done is high for exactly the one cycle in which quotient/remainder
    // first show the new result, and they hold until the next result or reset.

    localparam int CNT_W = $clog2(W + 1);

    div_state_t     state;
    div_state_t     state_next;
    logic [CNT_W-1:0] count;
    logic [W-1:0]   dividend_q;
    logic [W-1:0]   divisor_q;
    logic [W:0]     rem_q;
    logic [W:0]     rem_step;
    logic           q_bit;
    logic           accept;
    logic           zero_div;
    logic           last_step;

    div_step #(.W(W)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dividend_q[W-1]),
        .divisor      (divisor_q),
        .rem_out      (rem_step),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_div   = 1'b0;
        last_step  = 1'b0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
        zero_div   = (B == '0);
`endif
        case (state)
            IDLE, DONE: begin
                accept = start;
                if (start) begin
                    state_next = zero_div ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                last_step = (count == CNT_W'(1));
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quotient   <= '0;
            remainder  <= '0;
`ifdef SEQ_DIVIDER_DIVZERO_EN
            div_by_zero <= 1'b0;
`endif
        end else if (accept) begin
            dividend_q <= A;
            divisor_q  <= B;
            rem_q      <= '0;
            count      <= CNT_W'(W);
`ifdef SEQ_DIVIDER_DIVZERO_EN
            div_by_zero <= 1'b0;
            if (zero_div) begin
                count       <= '0;
                quotient    <= '1;
                remainder   <= A;
                div_by_zero <= 1'b1;
            end
`endif
        end else if (state == RUN) begin
            // The dividend register doubles as the quotient: bits shift out the top, results in at the bottom.
            rem_q      <= rem_step;
            dividend_q <= {dividend_q[W-2:0], q_bit};
            count      <= count - CNT_W'(1);
            if (last_step) begin
                quotient  <= {dividend_q[W-2:0], q_bit};
                remainder <= rem_step[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (W=4), with sequences for back-to-back and mid-run reset.
// Build with SEQ_DIVIDER_DIVZERO_EN to exercise the divide-by-zero early exit.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W = 4;
    localparam int MAX_CYC = 50;
`ifdef SEQ_DIVIDER_DIVZERO_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 5;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    div_state_t   fsm_state;
`ifdef SEQ_DIVIDER_DIVZERO_EN
    logic         div_by_zero;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t tbl[6];

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (a_in),
        .B         (b_in),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .fsm_state (fsm_state)
`ifdef SEQ_DIVIDER_DIVZERO_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one operation, return results, cycles until done (1 = first cycle after accept) and busy cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < MAX_CYC) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        q = quotient;
        r = remainder;
    endtask

    logic [W-1:0] q, r;
    int lat, bcnt, dcnt;

    initial begin
        tbl[0] = '{a: 4'd15, b: 4'd4, q: 4'd3,  r: 4'd3};
        tbl[1] = '{a: 4'd13, b: 4'd9, q: 4'd1,  r: 4'd4};
        tbl[2] = '{a: 4'd5,  b: 4'd9, q: 4'd0,  r: 4'd5};
        tbl[3] = '{a: 4'd12, b: 4'd8, q: 4'd1,  r: 4'd4};
        tbl[4] = '{a: 4'd10, b: 4'd1, q: 4'd10, r: 4'd0};
        tbl[5] = '{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_state", int'(fsm_state), int'(IDLE));
`ifdef SEQ_DIVIDER_DIVZERO_EN
        check("reset_div_by_zero", int'(div_by_zero), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed table, including latency and busy duration
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].a, tbl[i].b, q, r, lat, bcnt);
            check($sformatf("tbl%0d_quotient", i), int'(q), int'(tbl[i].q));
            check($sformatf("tbl%0d_remainder", i), int'(r), int'(tbl[i].r));
            check($sformatf("tbl%0d_latency", i), lat, (tbl[i].b == 0) ? DZ_LAT : 5);
            check($sformatf("tbl%0d_busy_cycles", i), bcnt, (tbl[i].b == 0) ? DZ_LAT - 1 : 4);
`ifdef SEQ_DIVIDER_DIVZERO_EN
            check($sformatf("tbl%0d_div_by_zero", i), int'(div_by_zero), (tbl[i].b == 0) ? 1 : 0);
`endif
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_done_one_cycle", i), int'(done), 0);
        end

        // Exhaustive operand sweep
        for (int ea = 0; ea < 16; ea++) begin
            for (int eb = 0; eb < 16; eb++) begin
                do_op(W'(ea), W'(eb), q, r, lat, bcnt);
                check($sformatf("ex_q_%0d_%0d", ea, eb), int'(q), (eb == 0) ? 15 : ea / eb);
                check($sformatf("ex_r_%0d_%0d", ea, eb), int'(r), (eb == 0) ? ea : ea % eb);
                check($sformatf("ex_lat_%0d_%0d", ea, eb), lat, (eb == 0) ? DZ_LAT : 5);
            end
        end

        // Back-to-back with start held high; operand changes during RUN must not matter
        @(negedge clk);
        a_in  = 4'd15;
        b_in  = 4'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_first_busy", int'(busy), 1);
        a_in = 4'd0;
        b_in = 4'd1;
        lat  = 1;
        while (!done && lat < MAX_CYC) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_first_latency", lat, 5);
        check("b2b_first_quotient", int'(quotient), 3);
        check("b2b_first_remainder", int'(remainder), 3);
        a_in = 4'd13;
        b_in = 4'd9;
        @(posedge clk);
        #1;
        check("b2b_no_gap_busy", int'(busy), 1);
        check("b2b_no_gap_done", int'(done), 0);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < MAX_CYC) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_second_latency", lat, 5);
        check("b2b_second_quotient", int'(quotient), 1);
        check("b2b_second_remainder", int'(remainder), 4);

        // Reset during RUN cycle 2 aborts the operation
        @(negedge clk);
        a_in  = 4'd15;
        b_in  = 4'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_running", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_state", int'(fsm_state), int'(IDLE));
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        do_op(4'd13, 4'd9, q, r, lat, bcnt);
        check("after_abort_quotient", int'(q), 1);
        check("after_abort_remainder", int'(r), 4);
        check("after_abort_latency", lat, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
